// File: rtl/rr_arb_bin.sv
// Round-robin arbiter producing a registered binary grant index with valid/ready handshake.
// A rotating priority pointer advances past each accepted grant; the winner search is binary only.
module rr_arb_bin #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [WIDTH-1:0]             req,
    output logic                         bin_vld,
    input  logic                         bin_rdy,
    output logic [$clog2(WIDTH)-1:0]     bin
);

    localparam int unsigned WIDTH_LOG = $clog2(WIDTH);
    localparam logic [WIDTH_LOG:0] WIDTH_L = (WIDTH_LOG+1)'(WIDTH);

    logic [WIDTH_LOG-1:0] ptr;
    logic [WIDTH_LOG-1:0] ptr_nxt;
    logic [WIDTH_LOG-1:0] winner;
    logic [WIDTH_LOG:0]   bin_inc;
    logic                 hs;
    logic                 load;
    logic                 any_req;

    assign hs      = bin_vld & bin_rdy;
    assign load    = ~bin_vld | hs;
    assign any_req = |req;
    assign bin_inc = {1'b0, bin} + (WIDTH_LOG+1)'(1);

    // Explicit wrap so non-power-of-two widths return to 0 after WIDTH-1.
    always_comb begin
        ptr_nxt = ptr;
        if (hs) begin
            if (bin_inc == WIDTH_L) begin
                ptr_nxt = '0;
            end else begin
                ptr_nxt = bin_inc[WIDTH_LOG-1:0];
            end
        end
    end

    // First set request scanning from ptr_nxt upward, wrapping at WIDTH.
    always_comb begin
        logic               found;
        logic [WIDTH_LOG:0] idx;
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            idx = {1'b0, ptr_nxt} + (WIDTH_LOG+1)'(i);
            if (idx >= WIDTH_L) begin
                idx = idx - WIDTH_L;
            end
            if (!found && req[idx[WIDTH_LOG-1:0]]) begin
                found  = 1'b1;
                winner = idx[WIDTH_LOG-1:0];
            end
        end
    end

    // Offered grant is held until accepted; reset discards any same-cycle handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr     <= '0;
            bin_vld <= 1'b0;
            bin     <= '0;
        end else begin
            ptr <= ptr_nxt;
            if (load) begin
                bin_vld <= any_req;
                if (any_req) begin
                    bin <= winner;
                end
            end
        end
    end

endmodule

// File: tb/tb_rr_arb_bin.sv
// Self-checking bench for rr_arb_bin: hand-derived vector tables for WIDTH=32 and WIDTH=5,
// then random traffic against an independent reference model through a scoreboard queue.
module tb_rr_arb_bin;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, rdy_a, vld_a;
    logic [31:0] req_a;
    logic [4:0]  bin_a;

    logic        rst_b, rdy_b, vld_b;
    logic [4:0]  req_b;
    logic [2:0]  bin_b;

    rr_arb_bin #(.WIDTH(32)) u_a (
        .clk(clk), .rst(rst_a), .req(req_a),
        .bin_vld(vld_a), .bin_rdy(rdy_a), .bin(bin_a)
    );

    rr_arb_bin #(.WIDTH(5)) u_b (
        .clk(clk), .rst(rst_b), .req(req_b),
        .bin_vld(vld_b), .bin_rdy(rdy_b), .bin(bin_b)
    );

    typedef struct {
        logic        rst;
        logic        rdy;
        logic [31:0] req;
        logic        vld;
        int          bin;
    } vec_t;

    typedef struct {
        logic  vld;
        int    bin;
        string tag;
    } exp_t;

    vec_t tv_a[$];
    vec_t tv_b[$];
    exp_t sb_a[$];
    exp_t sb_b[$];

    int errors = 0;
    int checks = 0;

    // Reference model state, index 0 = WIDTH 32, index 1 = WIDTH 5.
    int m_ptr[2];
    int m_vld[2];
    int m_bin[2];

    function automatic void add_a(logic r, logic rdy, logic [31:0] rq, logic v, int b);
        vec_t t;
        t.rst = r; t.rdy = rdy; t.req = rq; t.vld = v; t.bin = b;
        tv_a.push_back(t);
    endfunction

    function automatic void add_b(logic r, logic rdy, logic [31:0] rq, logic v, int b);
        vec_t t;
        t.rst = r; t.rdy = rdy; t.req = rq; t.vld = v; t.bin = b;
        tv_b.push_back(t);
    endfunction

    function automatic void model_step(int k, int w, logic r, logic [31:0] rq, logic rdy);
        bit hs;
        int pn;
        if (r) begin
            m_ptr[k] = 0; m_vld[k] = 0; m_bin[k] = 0;
            return;
        end
        hs = (m_vld[k] != 0) && rdy;
        pn = hs ? (m_bin[k] + 1) % w : m_ptr[k];
        if (m_vld[k] == 0 || hs) begin
            if (rq != 0) begin
                for (int o = 0; o < w; o++) begin
                    if (rq[(pn + o) % w]) begin
                        m_bin[k] = (pn + o) % w;
                        break;
                    end
                end
            end
            m_vld[k] = (rq != 0) ? 1 : 0;
        end
        m_ptr[k] = pn;
    endfunction

    task automatic step_a(input logic r, input logic rdy, input logic [31:0] rq,
                          input logic ev, input int eb, input string tag);
        exp_t e;
        @(negedge clk);
        rst_a = r; rdy_a = rdy; req_a = rq;
        sb_a.push_back('{ev, eb, tag});
        @(posedge clk);
        #1;
        e = sb_a.pop_front();
        checks++;
        if (vld_a !== e.vld || 32'(bin_a) !== e.bin) begin
            errors++;
            $display("FAIL %s: got vld=%0b bin=%0d, expected vld=%0b bin=%0d",
                     e.tag, vld_a, bin_a, e.vld, e.bin);
        end
    endtask

    task automatic step_b(input logic r, input logic rdy, input logic [4:0] rq,
                          input logic ev, input int eb, input string tag);
        exp_t e;
        @(negedge clk);
        rst_b = r; rdy_b = rdy; req_b = rq;
        sb_b.push_back('{ev, eb, tag});
        @(posedge clk);
        #1;
        e = sb_b.pop_front();
        checks++;
        if (vld_b !== e.vld || 32'(bin_b) !== e.bin) begin
            errors++;
            $display("FAIL %s: got vld=%0b bin=%0d, expected vld=%0b bin=%0d",
                     e.tag, vld_b, bin_b, e.vld, e.bin);
        end
        checks++;
        if (!(bin_b <= 3'd4)) begin
            errors++;
            $display("FAIL %s_range: got bin=%0d, required bin<=4", e.tag, bin_b);
        end
    endtask

    initial begin
        logic [31:0] ones;
        logic [31:0] sp;
        logic [31:0] rq;
        logic        rdy;
        ones = '1;
        sp   = (32'd1 << 3) | (32'd1 << 17);

        rst_a = 1'b1; rdy_a = 1'b0; req_a = '0;
        rst_b = 1'b1; rdy_b = 1'b0; req_b = '0;

        // WIDTH=32: reset, full rotation, sparse, backpressure, idle, reset with handshake, wrap.
        add_a(1, 0, ones, 0, 0);
        add_a(1, 0, ones, 0, 0);
        add_a(0, 1, ones, 1, 0);
        for (int k = 1; k <= 33; k++) add_a(0, 1, ones, 1, k % 32);
        add_a(0, 1, sp, 1, 3);
        add_a(0, 1, sp, 1, 17);
        add_a(0, 1, sp, 1, 3);
        add_a(0, 1, sp, 1, 17);
        add_a(0, 1, 32'd1 << 3, 1, 3);
        add_a(0, 1, 32'd1 << 3, 1, 3);
        add_a(0, 1, 32'd1 << 5, 1, 5);
        for (int k = 0; k < 4; k++) add_a(0, 0, 32'd1 << 9, 1, 5);
        add_a(0, 1, 32'd1 << 9, 1, 9);
        add_a(0, 1, 32'd0, 0, 9);
        add_a(0, 1, 32'd0, 0, 9);
        add_a(0, 0, (32'd1 << 2) | (32'd1 << 12), 1, 12);
        add_a(0, 1, (32'd1 << 2) | (32'd1 << 12), 1, 2);
        add_a(0, 1, 32'd1 << 7, 1, 7);
        add_a(1, 1, ones, 0, 0);
        add_a(0, 1, ones, 1, 0);
        add_a(0, 1, ones, 1, 1);
        add_a(0, 1, 32'd1 << 31, 1, 31);
        add_a(0, 1, 32'd1 << 31, 1, 31);
        add_a(0, 1, (32'd1 << 31) | 32'd1, 1, 0);
        add_a(0, 1, (32'd1 << 31) | 32'd1, 1, 31);

        // WIDTH=5: wrap past 4, full rotation, idle, pointer retained.
        add_b(1, 0, 32'd0, 0, 0);
        add_b(0, 1, 32'b01000, 1, 3);
        add_b(0, 1, 32'b10001, 1, 4);
        add_b(0, 1, 32'b10001, 1, 0);
        add_b(0, 1, 32'b10001, 1, 4);
        add_b(0, 1, 32'b10001, 1, 0);
        for (int k = 1; k <= 5; k++) add_b(0, 1, 32'b11111, 1, k % 5);
        add_b(0, 1, 32'd0, 0, 0);
        add_b(0, 1, 32'd0, 0, 0);
        add_b(0, 0, 32'b00100, 1, 2);
        add_b(0, 0, 32'b00001, 1, 2);

        for (int i = 0; i < tv_a.size(); i++)
            step_a(tv_a[i].rst, tv_a[i].rdy, tv_a[i].req, tv_a[i].vld, tv_a[i].bin,
                   $sformatf("vec_a%0d", i));
        for (int i = 0; i < tv_b.size(); i++)
            step_b(tv_b[i].rst, tv_b[i].rdy, tv_b[i].req[4:0], tv_b[i].vld, tv_b[i].bin,
                   $sformatf("vec_b%0d", i));

        // Random traffic against the reference model.
        model_step(0, 32, 1'b1, '0, 1'b0);
        step_a(1'b1, 1'b0, '0, 1'b0, 0, "rnd_a_rst");
        for (int i = 0; i < 300; i++) begin
            rq  = (i % 7 == 0) ? 32'd0 : ($urandom() & $urandom() & $urandom());
            rdy = ($urandom_range(0, 3) != 0);
            model_step(0, 32, 1'b0, rq, rdy);
            step_a(1'b0, rdy, rq, m_vld[0][0], m_bin[0], $sformatf("rnd_a%0d", i));
        end

        model_step(1, 5, 1'b1, '0, 1'b0);
        step_b(1'b1, 1'b0, '0, 1'b0, 0, "rnd_b_rst");
        for (int i = 0; i < 300; i++) begin
            rq  = (i % 6 == 0) ? 32'd0 : 32'($urandom_range(0, 31));
            rdy = ($urandom_range(0, 3) != 0);
            model_step(1, 5, 1'b0, rq, rdy);
            step_b(1'b0, rdy, rq[4:0], m_vld[1][0], m_bin[1], $sformatf("rnd_b%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
